// File: rtl/xpt_sequencer.sv
// Execution-step sequencer: walks XPT from a captured first step to a captured last step,
// with wait-stalls, repeat-instruction re-entry and interrupt exit from a repeat loop.
module xpt_sequencer (
  input  logic       CLK,
  input  logic       notReset,
  input  logic       start,
  input  logic [4:0] first_xpt,
  input  logic [4:0] last_xpt,
  input  logic       repeat_op,
  input  logic       notWait,
  input  logic       B_zero,
  input  logic       int_req,
  output logic [4:0] XPT,
  output logic [4:0] notXPT,
  output logic       enable,
  output logic       busy,
  output logic       done,
  output logic       PC_Rewind,
  output logic [7:0] rep_count
);

  // state  | meaning
  // IDLE   | waiting for a valid start, XPT=0
  // RUN    | stepping XPT from first to last, decoders enabled
  // REPEAT | one-cycle re-entry of a repeat instruction, PC rewound
  // DONE   | one-cycle completion pulse, XPT=0
  typedef enum logic [1:0] {IDLE, RUN, REPEAT, DONE} state_t;

  state_t     state, state_nxt;
  logic [4:0] xpt_q, xpt_nxt;
  logic [4:0] first_q, first_nxt;
  logic [4:0] last_q, last_nxt;
  logic       rep_q, rep_nxt;
  logic       rewind_q, rewind_nxt;
  logic [7:0] cnt_q, cnt_nxt;

  always_ff @(posedge CLK) begin
    if (!notReset) begin
      state    <= IDLE;
      xpt_q    <= '0;
      first_q  <= '0;
      last_q   <= '0;
      rep_q    <= 1'b0;
      rewind_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      xpt_q    <= xpt_nxt;
      first_q  <= first_nxt;
      last_q   <= last_nxt;
      rep_q    <= rep_nxt;
      rewind_q <= rewind_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    xpt_nxt    = xpt_q;
    first_nxt  = first_q;
    last_nxt   = last_q;
    rep_nxt    = rep_q;
    rewind_nxt = 1'b0;
    cnt_nxt    = cnt_q;
    case (state)
      IDLE: begin
        if (start && (first_xpt <= last_xpt)) begin
          first_nxt = first_xpt;
          last_nxt  = last_xpt;
          rep_nxt   = repeat_op;
          xpt_nxt   = first_xpt;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (notWait) begin
          if (xpt_q < last_q) begin
            xpt_nxt = xpt_q + 5'd1;
          end else if (rep_q && !B_zero && !int_req) begin
            rewind_nxt = 1'b1;
            state_nxt  = REPEAT;
          end else begin
            // A pending interrupt breaks the repeat loop but rewinds PC so it resumes later
            rewind_nxt = rep_q && !B_zero && int_req;
            xpt_nxt    = '0;
            state_nxt  = DONE;
          end
        end
      end
      REPEAT: begin
        xpt_nxt   = first_q;
        cnt_nxt   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        state_nxt = RUN;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        xpt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign XPT       = xpt_q;
  assign notXPT    = ~xpt_q;
  assign enable    = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign PC_Rewind = rewind_q;
  assign rep_count = cnt_q;

endmodule

// File: doc/xpt_sequencer.md
XPT_SEQUENCER -- requirements
Module: xpt_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port notReset, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port start, input, 1, opcode decoded and step window valid; sampled only in IDLE.
REQ-004 SHALL have port first_xpt, input, 5, first execution step of the instruction; captured on accepted start.
REQ-005 SHALL have port last_xpt, input, 5, final execution step; captured on accepted start.
REQ-006 SHALL have port repeat_op, input, 1, repeat form (INIR/INDR class); captured on accepted start.
REQ-007 SHALL have port notWait, input, 1, active-low stall from I/O or memory; sampled every RUN cycle.
REQ-008 SHALL have port B_zero, input, 1, B register equals zero; sampled only at the final step.
REQ-009 SHALL have port int_req, input, 1, pending interrupt; sampled only at the final step.
REQ-010 SHALL have port XPT, output, 5, current execution step to the op decoders.
REQ-011 SHALL have port notXPT, output, 5, bitwise complement of XPT at all times.
REQ-012 SHALL have port enable, output, 1, decoder enable; high only in RUN.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse on instruction completion.
REQ-015 SHALL have port PC_Rewind, output, 1, one-cycle pulse; PC minus 2 for repeat re-entry.
REQ-016 SHALL have port rep_count, output, 8, repeat iterations of the current instruction, saturating.

Function
REQ-017 SHALL implement states IDLE, RUN, REPEAT, DONE, registered.
REQ-018 IDLE: start=1 with first_xpt<=last_xpt SHALL capture first_xpt, last_xpt and repeat_op, load XPT=first_xpt, clear rep_count, and enter RUN next cycle.
REQ-019 IDLE: start=1 with first_xpt>last_xpt SHALL be ignored; state remains IDLE and outputs are unchanged.
REQ-020 RUN, notWait=0: SHALL hold XPT with enable high; no other state change.
REQ-021 RUN, notWait=1, XPT<captured last: SHALL increment XPT by 1.
REQ-022 RUN, notWait=1, XPT==captured last: repeat_op=1, B_zero=0, int_req=0 SHALL enter REPEAT.
REQ-023 RUN, notWait=1, XPT==captured last: repeat_op=1, B_zero=0, int_req=1 SHALL pulse PC_Rewind and enter DONE in the same edge, so the instruction re-executes after the interrupt.
REQ-024 RUN, notWait=1, XPT==captured last: all other cases SHALL enter DONE.
REQ-025 REPEAT (one cycle): SHALL have enable=0 and PC_Rewind=1, reload XPT=captured first, increment rep_count saturating at 255, and return to RUN.
REQ-026 DONE (one cycle): SHALL have done=1, enable=0, XPT=0, and go to IDLE; start during DONE SHALL be ignored.
REQ-027 start SHALL be ignored in RUN and REPEAT; captured values are stable for the whole instruction.
REQ-028 first_xpt==last_xpt SHALL give a single-step RUN, with stall rules still applied.
REQ-029 In IDLE and DONE, XPT SHALL be 0.
REQ-030 B_zero and int_req SHALL have no effect outside the final RUN step.

Reset
REQ-031 notReset=0 at a clock edge SHALL force IDLE in any state, including mid-RUN and REPEAT.
REQ-032 Reset SHALL set the following values: XPT=0, notXPT=5'b11111, enable=0, busy=0, done=0, PC_Rewind=0, rep_count=0, and clear the captured values.
REQ-033 start SHALL be ignored while notReset=0.

Verification
REQ-034 Single run: start with first=4, last=11, repeat_op=0, notWait=1 -> XPT steps 4..11 over 8 cycles, then done for 1 cycle, then IDLE with XPT=0.
REQ-035 Stall: same as REQ-034 with notWait=0 for 3 cycles at XPT=9 -> XPT holds 9 for those 3 cycles; done arrives 3 cycles later than in REQ-034.
REQ-036 Repeat: repeat_op=1, B_zero=0 at the first two final steps and 1 at the third -> two REPEAT cycles with PC_Rewind pulses, rep_count=2, then done.
REQ-037 Interrupt exit: repeat_op=1, B_zero=0, int_req=1 at the final step -> PC_Rewind and DONE together, no REPEAT, rep_count unchanged.
REQ-038 Boundaries: start with first=12, last=5 -> ignored; first=last=7 -> one RUN cycle then done.
REQ-039 Reset mid-op: notReset=0 at XPT=8 -> next cycle all outputs equal the REQ-032 values; start on the following cycle is accepted normally.
